// File: rtl/gearbox_tx_66_64_pkg.sv
// Shared PCS definitions for the 10GBASE-R transmit gearbox: sync headers,
// sequence length, block/word widths and the 66-bit block layout.
package gearbox_tx_66_64_pkg;

  localparam logic [1:0] SYNC_DATA   = 2'b01;
  localparam logic [1:0] SYNC_CTRL   = 2'b10;

  localparam int GBX_SEQ_LEN = 33;
  localparam int BLOCK_W     = 66;
  localparam int WORD_W      = 64;

  localparam int         SEQ_W     = 6;
  localparam logic [5:0] SEQ_DRAIN = 6'(GBX_SEQ_LEN - 1);

  // Packed so that header lands in bits [1:0]: bit 0 is first on the line.
  typedef struct packed {
    logic [63:0] payload;
    logic [1:0]  header;
  } pcs_block_t;

endpackage

// File: rtl/gearbox_tx_66_64_seq.sv
// Sequence pacing for the TX gearbox: 0..32 position counter, upstream ready
// and underflow detection with a saturating event counter.
module gearbox_tx_seq
  import gearbox_tx_66_64_pkg::*;
#(
  parameter int UFL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic [SEQ_W-1:0]     seq,
  output logic                 in_ready,
  output logic                 ufl_ins,
  output logic                 ufl,
  output logic [UFL_CNT_W-1:0] ufl_cnt
);

  logic [SEQ_W-1:0] seq_nxt;

  // Position 32 is the drain slot: no block taken, residual flushed.
  always_comb begin
    in_ready = (seq != SEQ_DRAIN);
    ufl_ins  = in_ready & ~in_valid;
    seq_nxt  = (seq == SEQ_DRAIN) ? '0 : seq + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq     <= '0;
      ufl     <= 1'b0;
      ufl_cnt <= '0;
    end else begin
      seq <= seq_nxt;
      ufl <= ufl_ins;
      if (ufl_ins && (ufl_cnt != {UFL_CNT_W{1'b1}}))
        ufl_cnt <= ufl_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gearbox_tx_66_64.sv
// Transmit 66b->64b gearbox: packs 32 blocks into 33 serializer words,
// inserting an invalid-header block whenever upstream has nothing to send.
module gearbox_tx_66_64
  import gearbox_tx_66_64_pkg::*;
#(
  parameter logic [1:0]  UFL_HEADER  = 2'b00,
  parameter logic [63:0] UFL_PAYLOAD = 64'h0,
  parameter int          UFL_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           in_header,
  input  logic [63:0]          in_payload,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [63:0]          out_data,
  output logic                 out_valid,
  output logic [5:0]           seq,
  output logic                 ufl,
  output logic [UFL_CNT_W-1:0] ufl_cnt
);

  // Handshake: a block transfers when in_valid && in_ready at a rising edge.
  // in_ready depends only on the sequence position, never on in_valid; when
  // in_ready is low the upstream holds its block for the following cycle.
  // When in_ready is high and in_valid is low, a filler block is sent instead.

  logic        ufl_ins;
  pcs_block_t  blk;
  logic [6:0]  r;
  logic [63:0] residual;
  logic [63:0] res_masked;
  logic [127:0] c;

  gearbox_tx_seq #(
    .UFL_CNT_W (UFL_CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .seq      (seq),
    .in_ready (in_ready),
    .ufl_ins  (ufl_ins),
    .ufl      (ufl),
    .ufl_cnt  (ufl_cnt)
  );

  // The residual holds r = 2*seq valid bits; the new block lands just above them.
  always_comb begin
    blk.payload = ufl_ins ? UFL_PAYLOAD : in_payload;
    blk.header  = ufl_ins ? UFL_HEADER  : in_header;
    r           = {seq, 1'b0};
    res_masked  = residual & ~({64{1'b1}} << r);
    c           = {64'h0, res_masked} | (128'(blk) << r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residual  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      if (in_ready) begin
        out_data <= c[63:0];
        residual <= c[127:64];
      end else begin
        out_data <= residual;
        residual <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gearbox_tx_66_64.sv
// Bench for gearbox_tx_66_64: a line-level bit-queue model (66 bits in per
// accepted slot, 64 bits out per cycle) checked against the DUT every cycle.
module tb_gearbox_tx_66_64;
  import gearbox_tx_66_64_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_header = '0;
  logic [63:0] in_payload = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic [5:0]  seq;
  logic        ufl;
  logic [7:0]  ufl_cnt;

  gearbox_tx_66_64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_header  (in_header),
    .in_payload (in_payload),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .seq        (seq),
    .ufl        (ufl),
    .ufl_cnt    (ufl_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Line model: bits queued in transmission order.
  bit          bitq[$];
  int          model_cycle;
  logic [7:0]  exp_cnt;
  logic        exp_ufl;
  logic [63:0] exp_word;

  logic [63:0] pay_ctr = 64'h0;
  logic [1:0]  cur_h = SYNC_DATA;
  logic [63:0] cur_p = 64'h0;
  bit          alt = 1'b0;
  bit          need_new = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    bitq.delete();
    model_cycle = 0;
    exp_cnt     = 8'h0;
    exp_ufl     = 1'b0;
    exp_word    = 64'h0;
    need_new    = 1'b1;
  endtask

  // One clock: drive, check pre-edge ready/seq, advance model, check outputs.
  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] p);
    logic        ready;
    logic [65:0] blk;
    in_valid   = v;
    in_header  = h;
    in_payload = p;
    ready = (model_cycle % GBX_SEQ_LEN) != (GBX_SEQ_LEN - 1);
    check("seq", 64'(seq), 64'(model_cycle % GBX_SEQ_LEN));
    check("in_ready", 64'(in_ready), 64'(ready));
    if (ready) begin
      blk = v ? {p, h} : {64'h0, 2'b00};
      for (int i = 0; i < BLOCK_W; i++) bitq.push_back(blk[i]);
    end
    for (int i = 0; i < WORD_W; i++) exp_word[i] = bitq.pop_front();
    exp_ufl = ready && !v;
    if (exp_ufl && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    model_cycle++;
    @(posedge clk);
    #1;
    check("out_data", out_data, exp_word);
    check("out_valid", 64'(out_valid), 64'd1);
    check("ufl", 64'(ufl), 64'(exp_ufl));
    check("ufl_cnt", 64'(ufl_cnt), 64'(exp_cnt));
  endtask

  // mode 0: incrementing data blocks; 1: alternating data/ctrl; 2: random, gappy.
  task automatic traffic(input int n, input int mode);
    logic v;
    for (int k = 0; k < n; k++) begin
      if (need_new) begin
        case (mode)
          0: begin cur_h = SYNC_DATA; cur_p = pay_ctr; pay_ctr = pay_ctr + 64'd1; end
          1: begin cur_h = alt ? SYNC_CTRL : SYNC_DATA; alt = ~alt; cur_p = {$urandom, $urandom}; end
          default: begin cur_h = 2'($urandom_range(0, 3)); cur_p = {$urandom, $urandom}; end
        endcase
        need_new = 1'b0;
      end
      v = (mode == 2) ? ($urandom_range(0, 9) != 0) : 1'b1;
      if (v && ((model_cycle % GBX_SEQ_LEN) != (GBX_SEQ_LEN - 1))) need_new = 1'b1;
      step(v, cur_h, cur_p);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"}, out_data, 64'h0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_seq"}, 64'(seq), 64'd0);
    check({tag, "_ufl"}, 64'(ufl), 64'd0);
    check({tag, "_ufl_cnt"}, 64'(ufl_cnt), 64'd0);
  endtask

  initial begin
    model_reset();
    // Power-on reset
    #12;
    check_reset_outputs("rst");
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Continuous data, two full sequences plus wrap
    traffic(70, 0);
    // Alternating data/control headers
    traffic(40, 1);

    // Single missing block at sequence position 5
    while ((model_cycle % GBX_SEQ_LEN) != 5) traffic(1, 0);
    step(1'b0, cur_h, cur_p);
    traffic(40, 0);

    // Random gaps and headers
    traffic(100, 2);

    // Long starvation: counter must saturate, not wrap
    repeat (300) step(1'b0, SYNC_DATA, 64'h0);
    check("ufl_sat", 64'(ufl_cnt), 64'd255);
    traffic(20, 0);

    // Asynchronous reset in the middle of a sequence
    while ((model_cycle % GBX_SEQ_LEN) != 17) traffic(1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    model_reset();
    traffic(60, 0);
    traffic(40, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gearbox_tx_66_64.md
Name: gearbox_tx_66_64

Overview:
- Transmit-side 66b->64b gearbox for the 10GBASE-R PCS.
- Takes one 66-bit block per accepted cycle (2-bit sync header plus 64-bit scrambled payload) from the scrambler/encoder path.
- Emits one 64-bit word every clock to the PMA serializer.
- Paces the upstream with a 33-cycle sequence: 32 blocks are accepted per 33 output words. This produces the header/payload stream that the receive gearbox and block-sync logic align to.

Parameters:
- UFL_HEADER, 2'b00, sync header inserted when upstream fails to supply a block (invalid by design so RX block sync flags it).
- UFL_PAYLOAD, 64'h0, payload inserted on underflow.
- UFL_CNT_W, 8, width of saturating underflow counter.

Ports:
- clk  in  1  PCS TX clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_header  in  2  sync header of block; bit 0 transmitted first.
- in_payload  in  64  block payload; bit 0 transmitted immediately after in_header[1].
- in_valid  in  1  block present on in_header/in_payload.
- in_ready  out  1  gearbox consumes a block this cycle.
- out_data  out  64  serializer word; bit 0 transmitted first.
- out_valid  out  1  out_data carries gearbox output.
- seq  out  6  current sequence position 0..32 (debug/alignment).
- ufl  out  1  one-cycle pulse: underflow block inserted.
- ufl_cnt  out  UFL_CNT_W  saturating count of underflows.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: seq=0, residual=0, out_data=0, out_valid=0, ufl=0, ufl_cnt=0.
- Block bit vector B[65:0] = {in_payload, in_header}; B[0] is the first bit on the line.
- State: seq (0..32) and a 64-bit residual register; the number of valid residual bits is r = 2*seq (no separate fill counter).
- in_ready is combinational from seq: in_ready = (seq != 32). It does not depend on in_valid.
- Consume cycle (seq = s, 0..31):
  - C[127:0] = residual[r-1:0] | (B << r).
  - out_data <= C[63:0].
  - residual <= C[127:64], of which r+2 bits are valid.
  - seq <= s+1.
- Drain cycle (seq = 32):
  - out_data <= residual[63:0].
  - residual <= 0.
  - seq <= 0.
  - No block consumed.
- Latency: a block accepted in cycle N first appears on out_data in cycle N+1 (registered output).
- out_valid is set to 1 on the first clock after reset release and stays 1 until the next reset.
- Underflow: if in_ready=1 and in_valid=0, B = {UFL_PAYLOAD, UFL_HEADER} is used instead of the input.
  - ufl pulses 1 in the following cycle, aligned with the out_data word that begins the inserted block.
  - ufl_cnt increments and saturates at all-ones.
  - The sequence never stalls.
- in_valid while in_ready=0 (seq=32): input ignored, no error. Upstream must hold the block; it is taken the next cycle.
- Reset mid-sequence: all state discarded. After release the sequence restarts at seq=0 with an empty residual, so a partial block in flight is lost.
- Line-rate invariant: exactly 32 blocks (2112 bits) accepted per 33 words (2112 bits); no bits dropped or duplicated across the seq wrap.

Decomposition:
- Shared PCS package holds:
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10;
  - GBX_SEQ_LEN=33;
  - BLOCK_W=66, WORD_W=64;
  - typedef pcs_block_t {payload[63:0], header[1:0]}.
- Natural sub-module: gearbox_tx_seq, holding the seq counter, in_ready generation and underflow detect/counter.
- The shifter/residual datapath stays in the top.

Test Plan:
- Reset then constant in_valid=1 with header=2'b01, payload=incrementing 64'h0..: the serialized out_data bit stream equals the concatenation of blocks exactly. in_ready is low every 33rd cycle: seq=32, first at cycle 32 after release.
- Alternate SYNC_DATA/SYNC_CTRL blocks: out_data[1:0]=2'b01 in the first valid cycle; the second block's header sits at bits [3:2] of cycle 2. At seq=32, out_data holds the last 64 residual bits; on the following cycle seq=0 and the header is back at bits [1:0].
- Drop in_valid for one cycle at seq=5: a block {64'h0, 2'b00} is inserted, ufl pulses once, ufl_cnt=1, seq still advances to 6, and subsequent blocks are bit-exact.
- Hold in_valid=0 for 300 cycles: ufl_cnt saturates at 255 and does not wrap.
- Assert rst_n=0 asynchronously at seq=17 mid-clock: outputs go to 0 immediately. After release seq=0, out_valid goes to 1 after one clock, and the first new block is aligned at bit 0.
- Loopback of out_data into the receive gearbox plus block-sync RX: block_lock is asserted after 64 valid headers and no slip is issued.
